sample_capture: RTL and testbench

//  Acquisition side of the logic analyzer: samples CHANNEL_COUNT input channels at a programmable rate into a ring buffer.

---
 rtl/sample_capture_if.sv | 31 +++
 rtl/sample_capture.sv | 144 ++++++++++++++
 tb/tb_sample_capture.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_capture_if.sv
// Control, status and display-read signals of the logic-analyzer capture block.
// The master side configures/arms and reads back; the slave side is the capture engine.
interface sample_capture_if #(
  parameter int CHANNEL_COUNT = 10,
  parameter int DEPTH         = 640,
  parameter int DIV_W         = 16
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CHANNEL_COUNT-1:0] chan_in;
  logic [CHANNEL_COUNT-1:0] chan_enable;
  logic [CHANNEL_COUNT-1:0] trig_mask;
  logic [CHANNEL_COUNT-1:0] trig_value;
  logic [DIV_W-1:0]         sample_div;
  logic                     arm;
  logic [ADDR_W-1:0]        rd_addr;
  logic [CHANNEL_COUNT-1:0] rd_data;
  logic                     busy;
  logic                     waiting;
  logic                     done;

  modport master (
    output chan_in, chan_enable, trig_mask, trig_value, sample_div, arm, rd_addr,
    input  rd_data, busy, waiting, done
  );

  modport slave (
    input  chan_in, chan_enable, trig_mask, trig_value, sample_div, arm, rd_addr,
    output rd_data, busy, waiting, done
  );
endinterface

// File: rtl/sample_capture.sv
// Logic-analyzer acquisition: prescaled sampling into a ring buffer with pre/post trigger
// windows, frozen on completion and read back oldest-first by display column.
module sample_capture #(
  parameter int CHANNEL_COUNT = 10,
  parameter int DEPTH         = 640,
  parameter int PRETRIG       = 64,
  parameter int DIV_W         = 16
) (
  input  logic           clk,
  input  logic           reset,
  sample_capture_if.slave bus
);
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int POST_LEN = DEPTH - PRETRIG - 1;

  typedef enum logic [2:0] {S_IDLE, S_PRETRIG, S_WAIT_TRIG, S_POSTTRIG, S_DONE} state_t;

  state_t                   state_reg, state_next;
  logic [CHANNEL_COUNT-1:0] sync1_reg, sync2_reg, samp;
  logic [DIV_W-1:0]         pcnt_reg;
  logic                     strobe, capturing, wr_en, match;
  logic [CNT_W-1:0]         count_reg, count_next, count_inc;
  logic [ADDR_W-1:0]        wr_ptr_reg, trig_ptr_reg, trig_ptr_next;
  logic [ADDR_W-1:0]        start, phys;
  logic [ADDR_W:0]          phys_sum;
  logic                     in_range;
  logic [CHANNEL_COUNT-1:0] rd_data_reg;
  logic                     busy_reg, waiting_reg, done_reg;
  logic [CHANNEL_COUNT-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.chan_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign samp  = sync2_reg & bus.chan_enable;
  assign match = ((samp ^ bus.trig_value) & bus.trig_mask) == '0;

  assign strobe = (pcnt_reg == bus.sample_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pcnt_reg <= '0;
    else if (bus.arm || strobe)
      pcnt_reg <= '0;
    else
      pcnt_reg <= pcnt_reg + DIV_W'(1);
  end

  // arm wins over a coincident strobe: that sample is simply not taken.
  assign capturing = (state_reg == S_PRETRIG) || (state_reg == S_WAIT_TRIG) ||
                     (state_reg == S_POSTTRIG);
  assign wr_en     = capturing && strobe && !bus.arm;
  assign count_inc = count_reg + CNT_W'(1);

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    trig_ptr_next = trig_ptr_reg;
    if (bus.arm) begin
      count_next = '0;
      state_next = (PRETRIG == 0) ? S_WAIT_TRIG : S_PRETRIG;
    end else if (wr_en) begin
      unique case (state_reg)
        S_PRETRIG: begin
          count_next = count_inc;
          if (count_inc == CNT_W'(PRETRIG)) state_next = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (match) begin
            trig_ptr_next = wr_ptr_reg;
            count_next    = '0;
            state_next    = (POST_LEN == 0) ? S_DONE : S_POSTTRIG;
          end
        end
        S_POSTTRIG: begin
          count_next = count_inc;
          if (count_inc == CNT_W'(POST_LEN)) state_next = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      trig_ptr_reg <= '0;
      wr_ptr_reg   <= '0;
      busy_reg     <= 1'b0;
      waiting_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      trig_ptr_reg <= trig_ptr_next;
      if (wr_en)
        wr_ptr_reg <= (wr_ptr_reg == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + ADDR_W'(1);
      busy_reg     <= (state_next == S_PRETRIG) || (state_next == S_WAIT_TRIG) ||
                      (state_next == S_POSTTRIG);
      waiting_reg  <= (state_next == S_WAIT_TRIG);
      done_reg     <= (state_next == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= samp;
  end

  // Oldest sample sits PRETRIG slots before the trigger; DEPTH need not be a power of two.
  always_comb begin
    if (trig_ptr_reg >= ADDR_W'(PRETRIG))
      start = trig_ptr_reg - ADDR_W'(PRETRIG);
    else
      start = trig_ptr_reg + ADDR_W'(DEPTH - PRETRIG);
    phys_sum = {1'b0, start} + {1'b0, bus.rd_addr};
    if (phys_sum >= (ADDR_W+1)'(DEPTH))
      phys_sum = phys_sum - (ADDR_W+1)'(DEPTH);
  end

  assign phys     = phys_sum[ADDR_W-1:0];
  assign in_range = ({1'b0, bus.rd_addr} < (ADDR_W+1)'(DEPTH)) && !phys_sum[ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data_reg <= '0;
    else if (in_range)
      rd_data_reg <= mem[phys];
    else
      rd_data_reg <= '0;
  end

  assign bus.rd_data = rd_data_reg;
  assign bus.busy    = busy_reg;
  assign bus.waiting = waiting_reg;
  assign bus.done    = done_reg;
endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a 16-deep and a 12-deep instance share stimulus and are checked
// against captures rebuilt from the recorded probe history.
module tb_sample_capture;
  localparam int CC    = 4;
  localparam int DA    = 16;
  localparam int DB    = 12;
  localparam int P     = 4;
  localparam int DIV_W = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [CC-1:0]   chan_in, chan_enable, trig_mask, trig_value, chan_const;
  logic [DIV_W-1:0] sample_div;
  logic            arm;
  logic [3:0]      rd_addr;
  int              chan_mode = 2;
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              arm_cyc = 0;
  logic [CC-1:0]   hist [0:65535];

  always #5 clk = ~clk;

  sample_capture_if #(.CHANNEL_COUNT(CC), .DEPTH(DA), .DIV_W(DIV_W)) bus_a ();
  sample_capture_if #(.CHANNEL_COUNT(CC), .DEPTH(DB), .DIV_W(DIV_W)) bus_b ();

  assign bus_a.chan_in = chan_in;      assign bus_b.chan_in = chan_in;
  assign bus_a.chan_enable = chan_enable; assign bus_b.chan_enable = chan_enable;
  assign bus_a.trig_mask = trig_mask;  assign bus_b.trig_mask = trig_mask;
  assign bus_a.trig_value = trig_value; assign bus_b.trig_value = trig_value;
  assign bus_a.sample_div = sample_div; assign bus_b.sample_div = sample_div;
  assign bus_a.arm = arm;              assign bus_b.arm = arm;
  assign bus_a.rd_addr = rd_addr;      assign bus_b.rd_addr = rd_addr;

  sample_capture #(.CHANNEL_COUNT(CC), .DEPTH(DA), .PRETRIG(P), .DIV_W(DIV_W)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  sample_capture #(.CHANNEL_COUNT(CC), .DEPTH(DB), .PRETRIG(P), .DIV_W(DIV_W)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Probe pattern generator: 0 = counter, 1 = random, otherwise hold chan_const.
  initial begin
    chan_in = '0;
    forever begin
      @(negedge clk);
      case (chan_mode)
        0:       chan_in = chan_in + 1'b1;
        1:       chan_in = CC'($urandom);
        default: chan_in = chan_const;
      endcase
    end
  end

  // Edge n sees hist[n]; the arm edge index is remembered for the model.
  always @(posedge clk) begin
    hist[cyc] <= chan_in;
    if (arm) arm_cyc <= cyc;
    cyc <= cyc + 1;
  end

  // j-th sample after arm (j from 1): taken on edge arm+(div+1)*j, two flops behind the probe.
  function automatic logic [CC-1:0] sample_at(int j);
    return hist[arm_cyc + (int'(sample_div) + 1) * j - 2] & chan_enable;
  endfunction

  function automatic int trig_index();
    for (int j = P + 1; j < 20000; j++) begin
      if (arm_cyc + (int'(sample_div) + 1) * j - 2 >= cyc) return -1;
      if (((sample_at(j) ^ trig_value) & trig_mask) == '0) return j;
    end
    return -1;
  endfunction

  function automatic logic [CC-1:0] expect_rd(int depth, int t, int a);
    if (a >= depth || t < 0) return '0;
    return sample_at(t - P + a);
  endfunction

  function automatic int expect_done(int depth, int t);
    return arm_cyc + (int'(sample_div) + 1) * (t + depth - P - 1);
  endfunction

  task automatic capture(output int da, output int db, output int t);
    da = -1;
    db = -1;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    for (int k = 0; k < 4000 && (da < 0 || db < 0); k++) begin
      @(negedge clk);
      if (da < 0 && bus_a.done === 1'b1) da = cyc - 1;
      if (db < 0 && bus_b.done === 1'b1) db = cyc - 1;
    end
    t = trig_index();
    $display("capture: arm@%0d div=%0d trig_sample=%0d done_a@%0d done_b@%0d",
             arm_cyc, sample_div, t, da, db);
  endtask

  task automatic read_pair(input int a, output logic [CC-1:0] ra, output logic [CC-1:0] rb);
    @(negedge clk); rd_addr = 4'(a);
    @(negedge clk);
    ra = bus_a.rd_data;
    rb = bus_b.rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.waiting, bus_a.done, bus_a.rd_data} !== 7'b0) begin
      errors++;
      $display("FAIL reset_a: got %b expected 0", {bus_a.busy, bus_a.waiting, bus_a.done, bus_a.rd_data});
    end
    checks++;
    if ({bus_b.busy, bus_b.waiting, bus_b.done, bus_b.rd_data} !== 7'b0) begin
      errors++;
      $display("FAIL reset_b: got %b expected 0", {bus_b.busy, bus_b.waiting, bus_b.done, bus_b.rd_data});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy/done %b expected 00", {bus_a.busy, bus_a.done});
    end
  endtask

  task automatic test_count_trigger();
    int da, db, t;
    logic [CC-1:0] ra, rb;
    chan_mode = 0; chan_enable = '1; trig_mask = 4'hF; trig_value = 4'h9; sample_div = '0;
    capture(da, db, t);
    checks++;
    if (da !== expect_done(DA, t)) begin errors++; $display("FAIL count_done_a: got %0d expected %0d", da, expect_done(DA, t)); end
    checks++;
    if (db !== expect_done(DB, t)) begin errors++; $display("FAIL count_done_b: got %0d expected %0d", db, expect_done(DB, t)); end
    for (int a = 0; a < 16; a++) begin
      read_pair(a, ra, rb);
      checks++;
      if (ra !== expect_rd(DA, t, a)) begin errors++; $display("FAIL count_rd_a[%0d]: got %h expected %h", a, ra, expect_rd(DA, t, a)); end
      checks++;
      if (ra !== 4'(a + 5)) begin errors++; $display("FAIL count_seq_a[%0d]: got %h expected %h", a, ra, 4'(a + 5)); end
      checks++;
      if (rb !== expect_rd(DB, t, a)) begin errors++; $display("FAIL count_rd_b[%0d]: got %h expected %h", a, rb, expect_rd(DB, t, a)); end
    end
  endtask

  task automatic test_prescale();
    int da, db, t;
    logic [CC-1:0] ra, rb, d;
    logic [CC-1:0] col [16];
    chan_mode = 0; chan_enable = '1; trig_mask = 4'hF; trig_value = 4'h9; sample_div = 16'd2;
    capture(da, db, t);
    checks++;
    if (da !== expect_done(DA, t)) begin errors++; $display("FAIL div_done_a: got %0d expected %0d", da, expect_done(DA, t)); end
    for (int a = 0; a < 16; a++) begin
      read_pair(a, ra, rb);
      col[a] = ra;
      checks++;
      if (ra !== expect_rd(DA, t, a)) begin errors++; $display("FAIL div_rd_a[%0d]: got %h expected %h", a, ra, expect_rd(DA, t, a)); end
      checks++;
      if (rb !== expect_rd(DB, t, a)) begin errors++; $display("FAIL div_rd_b[%0d]: got %h expected %h", a, rb, expect_rd(DB, t, a)); end
    end
    checks++;
    if (col[4] !== 4'h9) begin errors++; $display("FAIL div_trig_word: got %h expected 9", col[4]); end
    for (int a = 0; a < 15; a++) begin
      d = col[a + 1] - col[a];
      checks++;
      if (d !== 4'd3) begin errors++; $display("FAIL div_step[%0d]: got %0d expected 3", a, d); end
    end
  endtask

  task automatic test_immediate();
    int da, db, t;
    logic [CC-1:0] ra, rb;
    chan_mode = 1; chan_enable = '1; trig_mask = '0; trig_value = 4'h3; sample_div = '0;
    capture(da, db, t);
    checks++;
    if (da - arm_cyc !== 16) begin errors++; $display("FAIL imm_done_a: got %0d expected 16", da - arm_cyc); end
    checks++;
    if (db - arm_cyc !== 12) begin errors++; $display("FAIL imm_done_b: got %0d expected 12", db - arm_cyc); end
    for (int a = 0; a < 16; a++) begin
      read_pair(a, ra, rb);
      checks++;
      if (ra !== expect_rd(DA, t, a)) begin errors++; $display("FAIL imm_rd_a[%0d]: got %h expected %h", a, ra, expect_rd(DA, t, a)); end
      checks++;
      if (rb !== expect_rd(DB, t, a)) begin errors++; $display("FAIL imm_rd_b[%0d]: got %h expected %h", a, rb, expect_rd(DB, t, a)); end
    end
  endtask

  task automatic test_enable();
    int da, db, t;
    logic [CC-1:0] ra, rb;
    chan_mode = 2; chan_const = 4'hF; chan_enable = 4'b0101; trig_mask = '0; sample_div = '0;
    repeat (3) @(negedge clk);
    capture(da, db, t);
    checks++;
    if (da !== expect_done(DA, t)) begin errors++; $display("FAIL en_done_a: got %0d expected %0d", da, expect_done(DA, t)); end
    for (int a = 0; a < 16; a++) begin
      read_pair(a, ra, rb);
      checks++;
      if (ra !== 4'h5) begin errors++; $display("FAIL en_rd_a[%0d]: got %h expected 5", a, ra); end
      checks++;
      if (rb !== ((a < DB) ? 4'h5 : 4'h0)) begin errors++; $display("FAIL en_rd_b[%0d]: got %h expected %h", a, rb, (a < DB) ? 4'h5 : 4'h0); end
    end
  endtask

  task automatic test_random_wrap();
    int da, db, t;
    logic [CC-1:0] ra, rb;
    for (int it = 0; it < 6; it++) begin
      chan_mode   = 1;
      chan_enable = CC'($urandom) | 4'b0001;
      trig_mask   = CC'($urandom);
      trig_value  = CC'($urandom) & chan_enable;
      sample_div  = DIV_W'($urandom_range(0, 3));
      capture(da, db, t);
      checks++;
      if (da !== expect_done(DA, t)) begin errors++; $display("FAIL rnd%0d_done_a: got %0d expected %0d", it, da, expect_done(DA, t)); end
      checks++;
      if (db !== expect_done(DB, t)) begin errors++; $display("FAIL rnd%0d_done_b: got %0d expected %0d", it, db, expect_done(DB, t)); end
      for (int a = 0; a < 16; a++) begin
        read_pair(a, ra, rb);
        checks++;
        if (ra !== expect_rd(DA, t, a)) begin errors++; $display("FAIL rnd%0d_rd_a[%0d]: got %h expected %h", it, a, ra, expect_rd(DA, t, a)); end
        checks++;
        if (rb !== expect_rd(DB, t, a)) begin errors++; $display("FAIL rnd%0d_rd_b[%0d]: got %h expected %h", it, a, rb, expect_rd(DB, t, a)); end
      end
    end
  endtask

  task automatic test_abort_reset();
    int k;
    chan_mode = 2; chan_const = 4'hF; chan_enable = '1; trig_mask = 4'hF; trig_value = 4'h0;
    sample_div = '0; rd_addr = 4'd4;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    k = 0;
    while (bus_a.waiting !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (bus_a.waiting !== 1'b1) begin errors++; $display("FAIL reach_wait: got waiting=%b expected 1", bus_a.waiting); end
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    checks++;
    if ({bus_a.busy, bus_a.waiting} !== 2'b10) begin errors++; $display("FAIL rearm_state: got busy/waiting %b expected 10", {bus_a.busy, bus_a.waiting}); end
    for (int s = 1; s <= P; s++) begin
      @(negedge clk);
      checks++;
      if (bus_a.waiting !== (s == P)) begin errors++; $display("FAIL rearm_count[%0d]: got waiting=%b expected %b", s, bus_a.waiting, s == P); end
    end
    trig_mask = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.waiting, bus_a.rd_data} !== 6'b10_1111) begin
      errors++;
      $display("FAIL post_state_a: got %b expected 101111", {bus_a.busy, bus_a.waiting, bus_a.rd_data});
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus_a.busy, bus_a.done, bus_a.rd_data} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_a: got %b expected 0", {bus_a.busy, bus_a.done, bus_a.rd_data});
    end
    checks++;
    if ({bus_b.busy, bus_b.done, bus_b.rd_data} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_b: got %b expected 0", {bus_b.busy, bus_b.done, bus_b.rd_data});
    end
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.done} !== 2'b00) begin errors++; $display("FAIL after_reset_idle: got %b expected 00", {bus_a.busy, bus_a.done}); end
  endtask

  initial begin
    arm = 1'b0; rd_addr = '0; chan_enable = '1; trig_mask = '0; trig_value = '0;
    sample_div = '0; chan_const = '0;
    test_reset();
    test_count_trigger();
    test_prescale();
    test_immediate();
    test_enable();
    test_random_wrap();
    test_abort_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
